// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store unit: byte/half/word accesses against a
// word-wide memory, with misaligned accesses split over two cycles.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t      state;
  logic [29:0] n_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [23:0] hold_q;

  logic [29:0] n, n1;
  logic [1:0]  off, a_off;
  logic [2:0]  a_f3, sz;
  logic        sec, bad_f3, oor, split_i, flt;
  logic [3:0]  szm, bmask;
  logic [7:0]  m8;
  logic [5:0]  shft, shinv;
  logic [31:0] sdata, raw, merged, ext;

  assign n   = addr[31:2];
  assign off = addr[1:0];
  assign n1  = n + 30'd1;
  assign sec = (state == SPLIT);

  always_comb begin
    case (funct3[1:0])
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
  end

  assign bad_f3  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (req_we && funct3[2]);
  assign split_i = ({1'b0, off} + sz) > 3'd4;
  // N+1 wrap at the top of the address space is caught because N itself is out of range
  assign oor     = ({2'b00, n} >= 32'(MEM_WORDS)) ||
                   (split_i && ({2'b00, n1} >= 32'(MEM_WORDS)));
  assign flt     = req_valid && (bad_f3 || oor);

  assign a_f3  = sec ? f3_q  : funct3;
  assign a_off = sec ? off_q : off;

  always_comb begin
    case (a_f3[1:0])
      2'b00:   szm = 4'b0001;
      2'b01:   szm = 4'b0011;
      default: szm = 4'b1111;
    endcase
  end

  // Byte lanes touched in this word: low nibble for the first word, high for the second
  assign m8    = {4'b0000, szm} << a_off;
  assign bmask = sec ? m8[7:4] : m8[3:0];
  assign shft  = {1'b0, a_off, 3'b000};
  assign shinv = {(3'd4 - {1'b0, a_off}), 3'b000};

  assign sdata = sec ? (wdata >> shinv) : (wdata << shft);
  assign raw   = sec ? ({8'h00, hold_q} | (mem_RD << shinv)) : (mem_RD >> shft);

  always_comb begin
    for (int k = 0; k < 4; k++)
      merged[8*k +: 8] = bmask[k] ? sdata[8*k +: 8] : mem_RD[8*k +: 8];
  end

  always_comb begin
    case (a_f3)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b010:  ext = raw;
      3'b100:  ext = {24'h0, raw[7:0]};
      3'b101:  ext = {16'h0, raw[15:0]};
      default: ext = 32'h0;
    endcase
  end

  // Outputs are combinational so store RMW and loads complete in the same cycle
  always_comb begin
    rdata  = 32'h0;
    stall  = 1'b0;
    fault  = 1'b0;
    mem_A  = 32'h0;
    mem_WD = 32'h0;
    mem_WE = 1'b0;
    if (reset) begin
      if (sec) begin
        mem_A  = {n_q + 30'd1, 2'b00};
        mem_WE = we_q;
        mem_WD = we_q ? merged : 32'h0;
        rdata  = we_q ? 32'h0 : ext;
      end else if (req_valid) begin
        if (flt) begin
          fault = 1'b1;
        end else begin
          mem_A  = {n, 2'b00};
          mem_WE = req_we;
          mem_WD = req_we ? merged : 32'h0;
          stall  = split_i;
          rdata  = (req_we || split_i) ? 32'h0 : ext;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      n_q    <= '0;
      off_q  <= '0;
      f3_q   <= '0;
      we_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && !flt && split_i) begin
          state  <= SPLIT;
          n_q    <= n;
          off_q  <= off;
          f3_q   <= funct3;
          we_q   <= req_we;
          hold_q <= req_we ? 24'h0 : raw[23:0];
        end
        SPLIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-level memory model plus literal
// scenario checks for extension, merging, splitting, faults and reset abort.
module tb_load_store_unit;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;
  logic        stall, fault, mem_WE;

  logic [31:0] dmem [0:MW-1];
  logic [7:0]  ref_b [0:4*MW-1];

  int tests = 0;
  int fails = 0;

  logic [31:0] got_rdata, c1_A;
  logic        c1_stall, c1_fault;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .fault(fault), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  assign mem_RD = dmem[mem_A[11:2]];
  always @(posedge clk) if (mem_WE) dmem[mem_A[11:2]] <= mem_WD;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    dmem[i] <= v;
    for (int b = 0; b < 4; b++) ref_b[4*i+b] = v[8*b +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
  endfunction

  function automatic int f3_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    longint last;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    last  = longint'(a) + f3_bytes(f3) - 1;
    return !legal || (last >= 4*MW);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 0;
    for (int j = 0; j < f3_bytes(f3); j++) v |= 32'(ref_b[a+j]) << (8*j);
    if (f3 == 3'd0 && v[7])  v |= 32'hFFFFFF00;
    if (f3 == 3'd1 && v[15]) v |= 32'hFFFF0000;
    return v;
  endfunction

  // Drive one access starting just after a rising edge; check every cycle it occupies
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    logic flt, spl;
    logic [31:0] ld, base;
    int nb;
    flt  = m_fault(we, f3, a);
    nb   = f3_bytes(f3);
    spl  = !flt && ((a % 4) + nb > 4);
    ld   = (!flt && !we) ? m_load(f3, a) : 32'h0;
    base = a & ~32'h3;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    c1_stall = stall; c1_fault = fault; c1_A = mem_A; got_rdata = rdata;
    chk("c1_fault", {31'b0, fault}, {31'b0, flt});
    chk("c1_stall", {31'b0, stall}, {31'b0, spl});
    chk("c1_we",    {31'b0, mem_WE}, {31'b0, we && !flt});
    chk("c1_rdata", rdata, spl ? 32'h0 : ld);
    if (!flt) chk("c1_addr", mem_A, base);
    @(posedge clk); #1;
    if (spl) begin
      @(negedge clk);
      got_rdata = rdata;
      chk("c2_stall", {31'b0, stall}, 32'h0);
      chk("c2_fault", {31'b0, fault}, 32'h0);
      chk("c2_addr",  mem_A, base + 32'd4);
      chk("c2_we",    {31'b0, mem_WE}, {31'b0, we});
      chk("c2_rdata", rdata, ld);
      @(posedge clk); #1;
    end
    if (we && !flt) begin
      for (int j = 0; j < nb; j++) ref_b[a+j] = wd[8*j +: 8];
      for (int w = int'(a >> 2); w <= int'((a + nb - 1) >> 2); w++)
        chk("mem_word", dmem[w], ref_word(w));
    end
  endtask

  task automatic do_idle();
    req_valid = 1'b0; req_we = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    @(negedge clk);
    chk("idle_outs", {stall, fault, mem_WE, 29'b0}, 32'h0);
    chk("idle_addr", mem_A, 32'h0);
    chk("idle_rdata", rdata, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h13; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < MW; i++) set_word(i, $urandom);
    @(negedge clk);
    chk("rst_outs", {stall, fault, mem_WE, 29'b0}, 32'h0);
    chk("rst_addr", mem_A, 32'h0);
    chk("rst_wd", mem_WD, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    do_idle();

    // Sign/zero extension of a top byte
    set_word(0, 32'h44332211);
    do_access(1'b0, 3'b000, 32'h3, 32'h0);
    chk("lit_lb", got_rdata, 32'h00000044);
    do_access(1'b0, 3'b100, 32'h3, 32'h0);
    chk("lit_lbu", got_rdata, 32'h00000044);
    set_word(0, 32'h80000000);
    do_access(1'b0, 3'b000, 32'h3, 32'h0);
    chk("lit_lb_neg", got_rdata, 32'hFFFFFF80);

    set_word(0, 32'hAABBCCDD);
    do_access(1'b1, 3'b001, 32'h2, 32'h00001234);
    chk("lit_sh", dmem[0], 32'h1234CCDD);

    set_word(0, 32'h44332211); set_word(1, 32'h88776655);
    do_access(1'b0, 3'b010, 32'h1, 32'h0);
    chk("lit_lw_c1stall", {31'b0, c1_stall}, 32'h1);
    chk("lit_lw_c1addr", c1_A, 32'h0);
    chk("lit_lw", got_rdata, 32'h55443322);

    set_word(0, 32'h0); set_word(1, 32'h0);
    do_access(1'b1, 3'b010, 32'h3, 32'hDEADBEEF);
    chk("lit_sw_w0", dmem[0], 32'hEF000000);
    chk("lit_sw_w1", dmem[1], 32'h00DEADBE);

    // Reset pulsed during the second half of a split store
    set_word(0, 32'h0); set_word(1, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h3; wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("abort_c1stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_outs", {stall, fault, mem_WE, 29'b0}, 32'h0);
    chk("abort_addr", mem_A, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    chk("abort_w0", dmem[0], 32'hEF000000);
    chk("abort_w1", dmem[1], 32'h00000000);
    set_word(0, 32'hEF000000); set_word(1, 32'h0);
    do_access(1'b0, 3'b010, 32'h0, 32'h0);
    chk("abort_idle", {31'b0, c1_stall}, 32'h0);
    chk("abort_lw", got_rdata, 32'hEF000000);

    do_access(1'b0, 3'b010, 32'h00000FFD, 32'h0);
    chk("lit_oor", {31'b0, c1_fault}, 32'h1);
    do_access(1'b0, 3'b011, 32'h0, 32'h0);
    chk("lit_f3_011", {31'b0, c1_fault}, 32'h1);

    // Split LH followed directly by SB
    set_word(1, 32'hA1B2C3D4); set_word(2, 32'h55667788);
    do_access(1'b0, 3'b001, 32'h7, 32'h0);
    chk("lit_lh_split", got_rdata, 32'hFFFF88A1);
    do_access(1'b1, 3'b000, 32'h8, 32'h0000005A);
    chk("lit_sb", dmem[2], 32'h5566775A);
    do_idle();

    for (int t = 0; t < 600; t++) begin
      logic [31:0] a;
      int mode;
      mode = $urandom_range(0, 19);
      if (mode < 14)      a = $urandom_range(0, 4*MW-1);
      else if (mode < 18) a = $urandom_range(4*MW-16, 4*MW+3);
      else                a = $urandom;
      do_access(1'($urandom), 3'($urandom), a, $urandom);
      if ($urandom_range(0, 7) == 0) do_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 1024, number of 32-bit words in the attached data memory; byte addresses at or above MEM_WORDS*4 are out of range.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
REQ-004 req_valid  input  1  MEM-stage access request present this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  input  32  effective byte address from the ALU.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 rdata  output  32  load result, sign- or zero-extended.
REQ-010 stall  output  1  1 = pipeline must hold the request stable next cycle.
REQ-011 fault  output  1  1 = illegal access this cycle.
REQ-012 mem_A  output  32  word-aligned byte address to data memory (bits [1:0] = 00).
REQ-013 mem_WD  output  32  full-word write data to data memory.
REQ-014 mem_WE  output  1  data memory write enable.
REQ-015 mem_RD  input  32  combinational read data from data memory at mem_A.

Function
REQ-016 Byte order is little-endian; byte k of a word occupies bits [8k+7:8k].
REQ-017 Word index N = addr[31:2]; offset = addr[1:0].
REQ-018 An access is split when (funct3 = LW/SW and offset != 0) or (funct3 = LH/LHU/SH and offset = 3); byte accesses are never split.
REQ-019 An access faults when funct3 is 011, 110 or 111, or when N, or N+1 for a split access, is >= MEM_WORDS; funct3 110/111 with req_we=1 and 100/101 with req_we=1 also fault.
REQ-020 A faulting access completes in one cycle with fault=1, mem_WE=0, rdata=0, stall=0, and the FSM staying in IDLE.
REQ-021 The FSM has two states: IDLE and SPLIT.
REQ-022 IDLE, no req_valid: stall=0, fault=0, mem_WE=0, rdata=0, mem_A=0.
REQ-023 IDLE, unsplit access: single cycle, stall=0, mem_A={N,2'b00}.
- Store: mem_WE=1; mem_WD = mem_RD with the addressed bytes replaced by the low bytes of wdata (read-modify-write in the same cycle).
- Load: rdata is extracted from mem_RD and extended.
REQ-024 IDLE, split access: stall=1, mem_A={N,2'b00}, bytes offset..3 handled; transition to SPLIT at the clock edge.
- Load: those bytes are captured into a 3-byte holding register.
- Store: mem_WE=1 with those bytes merged.
REQ-025 SPLIT: mem_A={N+1,2'b00}, stall=0, remaining bytes in word N+1 starting at byte 0; return to IDLE at the next edge.
- Store: mem_WE=1 with the remaining wdata bytes merged.
- Load: rdata = holding bytes (low) concatenated with mem_RD bytes, then extended.
REQ-026 In SPLIT, req_valid, req_we, funct3, addr and wdata are required stable; the unit uses the registered N, offset, funct3 and req_we captured in IDLE.
REQ-027 Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW has no extension.
REQ-028 rdata is valid only in the cycle where req_valid=1, req_we=0, stall=0 and fault=0; otherwise it is 0.
REQ-029 Stores never drive rdata; it remains 0 during store cycles.
REQ-030 N+1 is computed in 30 bits; the wrap from 0x3FFFFFFF is covered by the range fault.

Reset
REQ-031 While reset==0: state=IDLE, holding register=0, stall=0, fault=0, mem_WE=0, mem_A=0, mem_WD=0, rdata=0.
REQ-032 Reset asserted in SPLIT aborts the access; the second-half write does not occur, and the first-half write already committed is not undone.
REQ-033 After reset deasserts, the first request is handled from IDLE.

Verification
REQ-034 Memory word 0=0x44332211; LB at addr 0x3 -> rdata=0x00000044, stall=0; LBU same address -> 0x00000044; with word0=0x80000000, LB at 0x3 -> 0xFFFFFF80.
REQ-035 Word 0=0xAABBCCDD; SH wdata=0x1234 at addr 0x2 -> word 0=0x1234CCDD, single cycle, mem_WE=1.
REQ-036 Word0=0x44332211, word1=0x88776655; LW at addr 0x1 -> cycle 1 stall=1, mem_A=0x0; cycle 2 stall=0, mem_A=0x4, rdata=0x55443322.
REQ-037 Both words 0; SW 0xDEADBEEF at addr 0x3 -> word0=0xEF000000, word1=0x00DEADBE, two cycles; with reset pulsed low in cycle 2 -> word0=0xEF000000, word1=0x00000000, state=IDLE.
REQ-038 LW at addr 0x00000FFD with MEM_WORDS=1024 -> fault=1, mem_WE=0, rdata=0, stall=0; funct3=011 at addr 0 -> fault=1.
REQ-039 Back-to-back: split LH at 0x7 followed directly by SB at 0x8 -> LH occupies two cycles, SB is accepted in the third cycle with correct byte merge.
